mem_bus_arbiter: RTL and testbench

- Shares the single byte-wide memory port between NUM_REQ bus masters, e.g. requester 0 = wasm ROM parser/loader, requester 1 = CPU core.
- Replaces per-master tri-state gating with a registered one-hot grant and plain muxes.
- Grants are held until the owning master releases its request. Ownership changes only after the memory handshake has fully drained.
- Advisory yield signalling plus round-robin ordering bound starvation.

---
 rtl/mem_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter: shares one byte-wide memory port between NUM_REQ masters.
// The grant is registered and one-hot, ownership is held until the owner releases
// its request, and masters are ordered round-robin. Ownership passes to the next
// master only after the memory handshake has dropped.

// Per-master slice: decodes "this master is the owner" and routes mem_ready to it.
module mem_bus_arbiter_lane #(
  parameter int IDX = 0
) (
  input  logic [2:0] owner,
  input  logic       owned,
  input  logic       mem_ready,
  output logic       sel,
  output logic       m_ready
);
  // sel stays valid through DRAIN so that the address mux can hold the last owner
  assign sel     = (owner == 3'(IDX));
  assign m_ready = owned & sel & mem_ready;
endmodule

module mem_bus_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 32,
  parameter int MAX_HOLD = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        yield,
  input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
  input  logic [NUM_REQ*8-1:0]      m_wdata,
  input  logic [NUM_REQ-1:0]        m_rd_en,
  input  logic [NUM_REQ-1:0]        m_wr_en,
  output logic [NUM_REQ-1:0]        m_ready,
  output logic [7:0]                m_rdata,
  output logic [2:0]                owner,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_wdata,
  output logic                      mem_rd_en,
  output logic                      mem_wr_en,
  input  logic [7:0]                mem_rdata,
  input  logic                      mem_ready
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt, yield_nxt;
  logic [2:0]         owner_nxt, rr_ptr, rr_nxt, win;
  logic [HW-1:0]      hold_cnt, hold_nxt;
  logic               win_vld;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0][7:0]        wdata_arr;
  logic [NUM_REQ-1:0]             sel;

  logic owned, active, req_own, req_other;
  logic own_rd, own_wr;

  assign addr_arr  = m_addr;
  assign wdata_arr = m_wdata;

  assign owned  = (state == OWNED);
  assign active = (state != IDLE);
  assign busy   = owned;

  // grant is one-hot on the owner while OWNED, so it doubles as the owner mask
  assign req_own   = |(req & grant);
  assign req_other = |(req & ~grant);

  assign m_rdata = mem_rdata;

  genvar k;
  generate
    for (k = 0; k < NUM_REQ; k++) begin : g_lane
      mem_bus_arbiter_lane #(.IDX(k)) u_lane (
        .owner     (owner),
        .owned     (owned),
        .mem_ready (mem_ready),
        .sel       (sel[k]),
        .m_ready   (m_ready[k])
      );
    end
  endgenerate

  // Round-robin search: first set req bit starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_vld && req[j]) begin
        win     = 3'(j);
        win_vld = 1'b1;
      end
    end
  end

  // AND-OR mux of the owner's request; addr/wdata hold through DRAIN, enables only in OWNED
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        mem_addr  = addr_arr[i];
        mem_wdata = wdata_arr[i];
        own_rd    = m_rd_en[i];
        own_wr    = m_wr_en[i];
      end
    end
    if (!active) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
    // write wins when a master raises both enables
    mem_wr_en = owned & own_wr;
    mem_rd_en = owned & own_rd & ~own_wr;
  end

  // Next-state and next-register values
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    yield_nxt = yield;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        yield_nxt = '0;
        if (win_vld) begin
          grant_nxt = NUM_REQ'(1) << win;
          owner_nxt = win;
          hold_nxt  = '0;
          state_nxt = OWNED;
        end
      end
      OWNED: begin
        if (!req_own) begin
          grant_nxt = '0;
          yield_nxt = '0;
          rr_nxt    = (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;
          state_nxt = DRAIN;
        end else begin
          if (hold_cnt != HW'(MAX_HOLD)) hold_nxt = hold_cnt + HW'(1);
          // yield follows other requesters once the hold budget is used up
          yield_nxt = (hold_cnt == HW'(MAX_HOLD) && req_other) ? grant : '0;
        end
      end
      DRAIN: begin
        // wait for the memory to drop ready so it is never seen by the next owner
        if (!mem_ready) state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        yield_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and arbitration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      yield    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      yield    <= yield_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (NUM_REQ=2, MAX_HOLD=4).
// Expectations are queued as stimulus is driven and compared when the DUT is sampled.
module tb_mem_bus_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req, grant, yield, m_rd_en, m_wr_en, m_ready;
  logic [NR*AW-1:0] m_addr;
  logic [NR*8-1:0] m_wdata;
  logic [7:0]      m_rdata, mem_wdata, mem_rdata;
  logic [2:0]      owner;
  logic            busy, mem_rd_en, mem_wr_en, mem_ready;
  logic [AW-1:0]   mem_addr;

  int n_vec = 0;
  int n_err = 0;
  bit inv_on = 1'b0;

  typedef enum int {S_GRANT, S_YIELD, S_MRDY, S_RDATA, S_BUSY, S_OWNER,
                    S_ADDR, S_WDATA, S_RD, S_WR} sig_e;
  typedef struct {string tag; sig_e sig; logic [31:0] val;} exp_t;
  exp_t sbq[$];

  mem_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .yield(yield),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
    .m_ready(m_ready), .m_rdata(m_rdata), .owner(owner), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] probe(input sig_e s);
    case (s)
      S_GRANT: return 32'(grant);
      S_YIELD: return 32'(yield);
      S_MRDY:  return 32'(m_ready);
      S_RDATA: return 32'(m_rdata);
      S_BUSY:  return 32'(busy);
      S_OWNER: return 32'(owner);
      S_ADDR:  return mem_addr;
      S_WDATA: return 32'(mem_wdata);
      S_RD:    return 32'(mem_rd_en);
      default: return 32'(mem_wr_en);
    endcase
  endfunction

  task automatic push(input sig_e s, input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = s; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic drain_sb();
    exp_t e;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, probe(e.sig), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Quiet-state expectation: everything idle toward memory and masters
  task automatic push_quiet(input string t);
    push(S_GRANT, {t, "_grant"}, 0);
    push(S_YIELD, {t, "_yield"}, 0);
    push(S_BUSY,  {t, "_busy"},  0);
    push(S_MRDY,  {t, "_mrdy"},  0);
    push(S_RD,    {t, "_rd"},    0);
    push(S_WR,    {t, "_wr"},    0);
    push(S_ADDR,  {t, "_addr"},  0);
    push(S_WDATA, {t, "_wdata"}, 0);
  endtask

  // Invariants sampled away from the clock edge
  always @(negedge clk) begin
    if (inv_on && rst_n) begin
      chk("inv_onehot", 32'(((grant & (grant - 1'b1)) != 0)), 0);
      chk("inv_rdwr",   32'(mem_rd_en & mem_wr_en), 0);
      chk("inv_en_idle", 32'((mem_rd_en | mem_wr_en) & ~busy), 0);
      chk("inv_mrdy",   32'((m_ready & ~grant) != 0), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; m_addr = '0; m_wdata = '0; m_rd_en = '0; m_wr_en = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #2;
    push_quiet("rst");
    push(S_OWNER, "rst_owner", 0);
    drain_sb();
    #9 rst_n = 1'b1;
    inv_on = 1'b1;

    // single master read
    req = 2'b01;
    step();
    m_addr[31:0] = 32'h10; m_rd_en = 2'b01; mem_ready = 1'b1; mem_rdata = 8'hAB;
    push(S_GRANT, "t1_grant", 2'b01);
    push(S_BUSY,  "t1_busy", 1);
    push(S_OWNER, "t1_owner", 0);
    push(S_ADDR,  "t1_addr", 32'h10);
    push(S_RD,    "t1_rd", 1);
    push(S_WR,    "t1_wr", 0);
    push(S_MRDY,  "t1_mrdy", 2'b01);
    push(S_RDATA, "t1_rdata", 8'hAB);
    drain_sb();
    req = '0; m_rd_en = '0; mem_ready = 1'b0;
    step();
    push(S_GRANT, "t1_drain_grant", 0);
    push(S_BUSY,  "t1_drain_busy", 0);
    drain_sb();
    step();
    push_quiet("t1_idle");
    drain_sb();

    // fresh reset so rr_ptr is 0 for the simultaneous-request case
    rst_n = 1'b0; #1 rst_n = 1'b1;
    req = 2'b11;
    step();
    push(S_GRANT, "t2_first", 2'b01);
    drain_sb();
    req = 2'b10;
    step();
    push(S_GRANT, "t2_drain", 0);
    drain_sb();
    step();
    push(S_GRANT, "t2_idle", 0);
    drain_sb();
    step();
    push(S_GRANT, "t2_second", 2'b10);
    push(S_OWNER, "t2_owner1", 1);
    drain_sb();
    req = 2'b01;
    step();
    step();
    push(S_GRANT, "t2_gap", 0);
    drain_sb();
    step();
    push(S_GRANT, "t2_third", 2'b01);
    push(S_OWNER, "t2_owner0", 0);
    drain_sb();

    // owner drops req while the memory is still ready
    m_addr[31:0] = 32'h44; m_rd_en = 2'b01; mem_ready = 1'b1;
    push(S_RD, "t3_rd_on", 1);
    drain_sb();
    req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      push(S_GRANT, $sformatf("t3_drain%0d_grant", i), 0);
      push(S_BUSY,  $sformatf("t3_drain%0d_busy", i), 0);
      push(S_RD,    $sformatf("t3_drain%0d_rd", i), 0);
      push(S_WR,    $sformatf("t3_drain%0d_wr", i), 0);
      push(S_MRDY,  $sformatf("t3_drain%0d_mrdy", i), 0);
      push(S_ADDR,  $sformatf("t3_drain%0d_addr", i), 32'h44);
      drain_sb();
    end
    mem_ready = 1'b0; m_rd_en = '0;
    step();
    push(S_GRANT, "t3_idle", 0);
    drain_sb();
    step();
    push(S_GRANT, "t3_next", 2'b10);
    drain_sb();

    // hold limit: master 0 owns while master 1 waits
    req = 2'b00;
    step();
    step();
    req = 2'b01;
    step();
    push(S_GRANT, "t4_grant", 2'b01);
    drain_sb();
    req = 2'b11;
    for (int i = 0; i < 4; i++) step();
    push(S_YIELD, "t4_yield_pre", 0);
    drain_sb();
    step();
    push(S_YIELD, "t4_yield_set", 2'b01);
    push(S_GRANT, "t4_still_owned", 2'b01);
    drain_sb();
    req = 2'b01;
    step();
    push(S_YIELD, "t4_yield_clr", 0);
    drain_sb();

    // read+write collision and non-owner isolation
    m_addr[31:0] = 32'h20; m_wdata[7:0] = 8'h5A; m_rd_en = 2'b01; m_wr_en = 2'b01;
    mem_ready = 1'b1;
    push(S_WR,    "t5_wr", 1);
    push(S_RD,    "t5_rd", 0);
    push(S_WDATA, "t5_wdata", 8'h5A);
    push(S_ADDR,  "t5_addr", 32'h20);
    drain_sb();
    m_addr[63:32] = 32'hDEAD; m_wdata[15:8] = 8'h33; m_rd_en = 2'b11; m_wr_en = 2'b11;
    push(S_WR,    "t5_iso_wr", 1);
    push(S_RD,    "t5_iso_rd", 0);
    push(S_WDATA, "t5_iso_wdata", 8'h5A);
    push(S_ADDR,  "t5_iso_addr", 32'h20);
    push(S_MRDY,  "t5_iso_mrdy", 2'b01);
    drain_sb();
    m_rd_en = 2'b01; m_wr_en = 2'b00;
    push(S_WR, "t5_iso2_wr", 0);
    push(S_RD, "t5_iso2_rd", 1);
    drain_sb();
    m_wr_en = 2'b01;

    // asynchronous reset in the middle of a write
    #1 rst_n = 1'b0;
    push_quiet("t6_rst");
    push(S_OWNER, "t6_owner", 0);
    drain_sb();
    req = 2'b10; m_rd_en = '0; m_wr_en = '0; mem_ready = 1'b0;
    #1 rst_n = 1'b1;
    step();
    push(S_GRANT, "t6_grant", 2'b10);
    push(S_OWNER, "t6_owner1", 1);
    drain_sb();

    inv_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
